// File: rtl/lsu.sv
// Memory-stage load/store unit: one transaction at a time over a word bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses as bus errors.
module lsu #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_in_valid,
   input  logic                  i_is_load,
   input  logic                  i_is_store,
   input  logic [2:0]            i_funct3,
   input  logic [DATA_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_store_data,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [DATA_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic [3:0]            o_mem_wstrb,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   input  logic                  i_mem_ack,
   output logic                  o_stall,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_load_data,
   output logic                  o_bus_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [DATA_WIDTH-1:0]   r_mem_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [3:0]              r_wstrb;
   logic                    r_we;
   logic                    r_load;
   logic [2:0]              r_f3;
   logic [1:0]              r_lane;
   logic [7:0]              r_cnt;
   logic                    r_err;
   logic [DATA_WIDTH-1:0]   r_load_data;

   logic                    w_accept;
   logic                    w_legal;
   logic                    w_trap;
   logic                    w_go;
   logic [1:0]              w_lane;
   logic [3:0]              w_strb;
   logic [DATA_WIDTH-1:0]   w_wdata;
   logic                    w_timeout;
   logic [7:0]              w_byte;
   logic [15:0]             w_half;
   logic [DATA_WIDTH-1:0]   w_ext;

   assign w_accept = (r_state == S_IDLE) && i_in_valid
                     && (i_is_load || i_is_store);

   always_comb begin
      w_legal = 1'b0;
      case (i_funct3)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = i_is_load;
         default:                w_legal = 1'b0;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_trap = ((i_funct3[1:0] == 2'b01) && i_addr[0])
                   || ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
   assign w_trap = 1'b0;
`endif

   assign w_go = w_legal && !w_trap;

   // Misaligned halves/words are forced down to their natural boundary
   always_comb begin
      w_lane = i_addr[1:0];
      case (i_funct3[1:0])
         2'b01:   w_lane = {i_addr[1], 1'b0};
         2'b10:   w_lane = 2'b00;
         default: w_lane = i_addr[1:0];
      endcase
   end

   always_comb begin
      w_strb  = 4'b0000;
      w_wdata = '0;
      case (i_funct3[1:0])
         2'b00: begin
            w_strb  = 4'b0001 << w_lane;
            w_wdata = {4{i_store_data[7:0]}};
         end
         2'b01: begin
            w_strb  = 4'b0011 << {w_lane[1], 1'b0};
            w_wdata = {2{i_store_data[15:0]}};
         end
         default: begin
            w_strb  = 4'b1111;
            w_wdata = i_store_data;
         end
      endcase
   end

   assign w_timeout = ({1'b0, r_cnt} + 9'd1) >= 9'(TIMEOUT_CYCLES);

   assign w_byte = i_mem_rdata[{r_lane, 3'b000} +: 8];
   assign w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

   always_comb begin
      w_ext = i_mem_rdata;
      case (r_f3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b100:  w_ext = {24'd0, w_byte};
         3'b101:  w_ext = {16'd0, w_half};
         default: w_ext = i_mem_rdata;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = w_go ? S_REQ : S_DONE;
         end
         S_REQ: begin
            if (i_mem_ack || w_timeout) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_mem_addr  <= '0;
         r_wdata     <= '0;
         r_wstrb     <= 4'b0000;
         r_we        <= 1'b0;
         r_load      <= 1'b0;
         r_f3        <= 3'b000;
         r_lane      <= 2'b00;
         r_cnt       <= 8'd0;
         r_err       <= 1'b0;
         r_load_data <= '0;
      end else if (w_accept) begin
         r_mem_addr  <= {i_addr[DATA_WIDTH-1:2], 2'b00};
         r_wdata     <= i_is_load ? '0 : w_wdata;
         r_wstrb     <= (w_go && !i_is_load) ? w_strb : 4'b0000;
         r_we        <= w_go && !i_is_load;
         r_load      <= i_is_load;
         r_f3        <= i_funct3;
         r_lane      <= w_lane;
         r_cnt       <= 8'd0;
         r_err       <= !w_go;
         r_load_data <= '0;
      end else if (r_state == S_REQ) begin
         r_cnt <= r_cnt + 8'd1;
         // Ack has priority over a coincident timeout
         if (i_mem_ack) begin
            r_err       <= 1'b0;
            r_load_data <= r_load ? w_ext : '0;
            r_we        <= 1'b0;
            r_wstrb     <= 4'b0000;
         end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_load_data <= '0;
            r_we        <= 1'b0;
            r_wstrb     <= 4'b0000;
         end
      end
   end

   assign o_mem_req   = (r_state == S_REQ);
   assign o_mem_we    = r_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_wdata;
   assign o_mem_wstrb = r_wstrb;
   assign o_stall     = w_accept || (r_state == S_REQ);
   assign o_done      = (r_state == S_DONE);
   assign o_load_data = r_load_data;
   assign o_bus_err   = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for lsu (TIMEOUT_CYCLES=4).
// Misalignment expectations follow LSU_MISALIGN_TRAP_EN.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        done;
   logic [31:0] load_data;
   logic        bus_err;

   always #5 clk = ~clk;

   lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_in_valid   (in_valid),
      .i_is_load    (is_load),
      .i_is_store   (is_store),
      .i_funct3     (funct3),
      .i_addr       (addr),
      .i_store_data (store_data),
      .o_mem_req    (mem_req),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .o_mem_wstrb  (mem_wstrb),
      .i_mem_rdata  (mem_rdata),
      .i_mem_ack    (mem_ack),
      .o_stall      (stall),
      .o_done       (done),
      .o_load_data  (load_data),
      .o_bus_err    (bus_err)
   );

   typedef struct {
      logic [31:0] ld;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // wt: wait states before ack (-1 = never ack); lat: cycles accept->done
   task automatic run_op(input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input int wt, input int lat, input logic e_req,
                         input logic [31:0] e_addr, input logic [31:0] e_wd,
                         input logic [3:0] e_strb, input logic [31:0] e_ld,
                         input logic e_err);
      exp_t e;
      exp_t got;
      int   c;
      int   nreq;
      logic seen;
      logic bad;
      logic e_we;
      e.ld  = e_ld;
      e.err = e_err;
      sb.push_back(e);
      e_we = e_req && st && !ld;
      @(negedge clk);
      in_valid   = 1'b1;
      is_load    = ld;
      is_store   = st;
      funct3     = f3;
      addr       = a;
      store_data = sd;
      #1;
      chk({tag, " stall@accept"}, 32'(stall), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      c    = 1;
      nreq = 0;
      seen = 1'b0;
      bad  = 1'b0;
      while (!done && c < 20) begin
         mem_ack = 1'b0;
         if (mem_req) begin
            nreq++;
            seen = 1'b1;
            if (!stall || mem_addr !== e_addr || mem_we !== e_we
                || mem_wstrb !== e_strb
                || (e_we && mem_wdata !== e_wd))
               bad = 1'b1;
            if (wt >= 0 && nreq == wt + 1) begin
               mem_ack   = 1'b1;
               mem_rdata = rd;
            end
         end else if (!e_req && mem_wstrb !== 4'b0000) begin
            bad = 1'b1;
         end
         @(negedge clk);
         c++;
      end
      mem_ack = 1'b0;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " latency"}, 32'(c), 32'(lat));
      chk({tag, " stall@done"}, 32'(stall), 32'd0);
      chk({tag, " req seen"}, 32'(seen), 32'(e_req));
      chk({tag, " bus fields"}, 32'(bad), 32'd0);
      if (sb.size() == 0) begin
         chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
      end else begin
         got = sb.pop_front();
         chk({tag, " load_data"}, load_data, got.ld);
         chk({tag, " bus_err"}, 32'(bus_err), 32'(got.err));
      end
      @(negedge clk);
      chk({tag, " done pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      funct3     = 3'b000;
      addr       = '0;
      store_data = '0;
      mem_rdata  = '0;
      mem_ack    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst outs", {mem_addr | mem_wdata | load_data}, 32'd0);
      chk("rst strb", {28'd0, mem_wstrb}, 32'd0);
      rst_n = 1'b1;

      run_op("SW", 0, 1, 3'b010, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 2, 1,
             32'h1000, 32'hDEADBEEF, 4'b1111, 32'h0, 0);
      run_op("LB", 1, 0, 3'b000, 32'h2003, 32'h0, 32'h80FF1234, 3, 5, 1,
             32'h2000, 32'h0, 4'b0000, 32'hFFFFFF80, 0);
      run_op("LBU", 1, 0, 3'b100, 32'h2003, 32'h0, 32'h80FF1234, 3, 5, 1,
             32'h2000, 32'h0, 4'b0000, 32'h00000080, 0);
      run_op("SH", 0, 1, 3'b001, 32'h3002, 32'h0000ABCD, 32'h0, 1, 3, 1,
             32'h3000, 32'hABCDABCD, 4'b1100, 32'h0, 0);
      run_op("LHU", 1, 0, 3'b101, 32'h3002, 32'h0, 32'hABCD0000, 0, 2, 1,
             32'h3000, 32'h0, 4'b0000, 32'h0000ABCD, 0);
      run_op("LH", 1, 0, 3'b001, 32'h3000, 32'h0, 32'h12348001, 0, 2, 1,
             32'h3000, 32'h0, 4'b0000, 32'hFFFF8001, 0);
      run_op("LW tmo", 1, 0, 3'b010, 32'h5000, 32'h0, 32'h0, -1, 5, 1,
             32'h5000, 32'h0, 4'b0000, 32'h0, 1);
      run_op("LW ack4", 1, 0, 3'b010, 32'h5004, 32'h0, 32'h11223344, 3, 5,
             1, 32'h5004, 32'h0, 4'b0000, 32'h11223344, 0);
      run_op("LD+ST", 1, 1, 3'b010, 32'h5008, 32'h55, 32'h01020304, 0, 2,
             1, 32'h5008, 32'h0, 4'b0000, 32'h01020304, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      run_op("LW mis", 1, 0, 3'b010, 32'h4002, 32'h0, 32'hCAFEF00D, 0, 1,
             0, 32'h4000, 32'h0, 4'b0000, 32'h0, 1);
      run_op("SH mis", 0, 1, 3'b001, 32'h4001, 32'h1234, 32'h0, 0, 1,
             0, 32'h4000, 32'h0, 4'b0000, 32'h0, 1);
`else
      run_op("LW mis", 1, 0, 3'b010, 32'h4002, 32'h0, 32'hCAFEF00D, 0, 2,
             1, 32'h4000, 32'h0, 4'b0000, 32'hCAFEF00D, 0);
      run_op("SH mis", 0, 1, 3'b001, 32'h4001, 32'h1234, 32'h0, 0, 2,
             1, 32'h4000, 32'h12341234, 4'b0011, 32'h0, 0);
`endif
      run_op("ILL ld", 1, 0, 3'b011, 32'h7000, 32'h0, 32'h0, 0, 1, 0,
             32'h7000, 32'h0, 4'b0000, 32'h0, 1);
      run_op("ILL sbu", 0, 1, 3'b100, 32'h7000, 32'hFF, 32'h0, 0, 1, 0,
             32'h7000, 32'h0, 4'b0000, 32'h0, 1);

      @(negedge clk);
      in_valid = 1'b1;
      #1;
      chk("nop stall", 32'(stall), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("nop req", 32'(mem_req), 32'd0);
      chk("nop done", 32'(done), 32'd0);

      @(negedge clk);
      in_valid = 1'b1;
      is_load  = 1'b1;
      funct3   = 3'b010;
      addr     = 32'h8000;
      @(negedge clk);
      in_valid = 1'b0;
      is_load  = 1'b0;
      @(negedge clk);
      chk("rstmid req", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid req0", 32'(mem_req), 32'd0);
      chk("rstmid stall0", 32'(stall), 32'd0);
      chk("rstmid done0", 32'(done), 32'd0);
      rst_n     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h12345678;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("late ack done", 32'(done), 32'd0);
      chk("late ack req", 32'(mem_req), 32'd0);
      chk("late ack ld", load_data, 32'd0);

      run_op("SB", 0, 1, 3'b000, 32'h6001, 32'h000000A5, 32'h0, 0, 2, 1,
             32'h6000, 32'hA5A5A5A5, 4'b0010, 32'h0, 0);

      chk("sb drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit in the memory stage, directly downstream of the execute-stage ALU; the ALU result is its effective address. Accepts one load or store per transaction and drives a variable-latency word-wide data-memory port with byte strobes. Sign- or zero-extends load data and returns a single-cycle done pulse. Stalls the pipeline while a transaction is outstanding.

Parameters:
DATA_WIDTH, 32, data and address width (block is specified for 32 only)
TIMEOUT_CYCLES, 255, maximum REQ cycles without mem_ack before bus error (1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  stage holds a valid instruction
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store (is_load and is_store both high: treated as load)
funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  effective address (ALU result)
store_data  in  32  rs2 value
mem_req  out  1  memory request, held until ack
mem_we  out  1  write enable
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes (0000 for loads)
mem_rdata  in  32  read word, valid with mem_ack
mem_ack  in  1  request complete
stall  out  1  hold upstream pipeline
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result, valid with done
bus_err  out  1  error qualifier, valid with done

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; mem_req, mem_we, done, bus_err, stall = 0; mem_addr, mem_wdata, mem_wstrb, load_data = 0; timeout counter = 0. Applies mid-transaction: request is dropped without waiting for ack.
- FSM states: IDLE, REQ, DONE.
- IDLE: accept when in_valid && (is_load || is_store). Register addr, store_data, funct3 and direction, then go to REQ. stall is combinationally high in the accept cycle. in_valid with neither op: ignored, no stall.
- Illegal funct3 (011, 110, 111; or 100/101 on store): no memory access. Go directly to DONE with bus_err=1.
- REQ: mem_req=1, and mem_addr/mem_we/mem_wdata/mem_wstrb stay stable every cycle. The counter increments each REQ cycle.
  - On mem_ack: capture the extended load result and go to DONE with bus_err=0.
  - If the counter reaches TIMEOUT_CYCLES without ack: go to DONE with bus_err=1 and load_data=0.
  - Ack in the same cycle as timeout: ack wins.
- DONE: done=1 for exactly one cycle and stall=0, so upstream advances. Then return to IDLE; a new op may be accepted in the following cycle. stall=1 throughout REQ.
- mem_ack outside REQ is ignored.
- Latency: zero-wait memory (ack in first REQ cycle) gives done 2 cycles after accept; each wait state adds 1 cycle.
- Store strobes:
  - SB: 0001<<addr[1:0], data {4{b}}.
  - SH: 0011<<{addr[1],1'b0}, data {2{h}}.
  - SW: 1111.
- Load select:
  - Byte lane addr[1:0]; half lane addr[1].
  - B/H sign-extend, BU/HU zero-extend, W passes through.
  - Stores return load_data=0.
- Misalignment (H with addr[0]=1; W with addr[1:0]!=0): see Optional Feature.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no memory request; go to DONE next cycle with bus_err=1, load_data=0, and no strobes ever asserted.
- Undefined: the low address bits are forced down (H clears addr[0], W clears addr[1:0]) and the access proceeds normally with bus_err=0.

Test Plan:
- SW addr=0x1000 data=0xDEADBEEF, ack on first REQ cycle -> mem_addr=0x1000, wstrb=1111, done 2 cycles after accept, stall low in done cycle.
- LB addr=0x2003, rdata=0x80FF_1234, ack after 3 wait cycles -> load_data=0xFFFFFF80, done at accept+5; LBU same -> 0x00000080.
- SH addr=0x3002 data=0x0000ABCD -> wstrb=1100, wdata=0xABCDABCD; LHU addr=0x3002 rdata=0xABCD0000 -> 0x0000ABCD.
- LW, TIMEOUT_CYCLES=4, no ack -> done with bus_err=1, load_data=0 after 4 REQ cycles. Repeat with ack on the 4th cycle -> bus_err=0.
- LW addr=0x4002 -> macro defined: no mem_req, bus_err=1. Undefined: mem_addr=0x4000, bus_err=0.
- rst_n low during REQ -> next cycle mem_req=0, stall=0, state IDLE. A late mem_ack is ignored; a fresh SB then completes normally.
